fir_coeff_pair_loader: RTL and testbench

- Consumes the 32-bit software register word carrying one packed FIR coefficient pair: bits [31:16] are the even tap (e.g. b22) and bits [15:0] are the odd tap (e.g. b23).
- Sits in the user_clk domain between the register output and the chan_packet FIR coefficient inputs.
- A new pair is accepted only after it has been stable for a programmable settle time.
- The accepted pair is applied atomically on a channel-frame boundary, so the FIR never runs a frame with mixed old/new taps.

---
 rtl/fir_coeff_pair_loader.sv | 105 ++++++++++
 tb/tb_fir_coeff_pair_loader.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/fir_coeff_pair_loader.sv
// Qualifies a packed FIR coefficient pair from the register word and applies it
// atomically on a channel-frame boundary once it has been stable long enough.
module fir_coeff_pair_loader #(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned CNT_WIDTH     = 8,
  parameter logic [15:0] RESET_HI      = 16'h0000,
  parameter logic [15:0] RESET_LO      = 16'h0000
) (
  input  logic                 user_clk,
  input  logic                 user_rst_n,
  input  logic [31:0]          reg_data,
  input  logic                 frame_sync,
  output logic [15:0]          coef_hi,
  output logic [15:0]          coef_lo,
  output logic                 coef_valid,
  output logic                 update_pending,
  output logic [CNT_WIDTH-1:0] update_count
);

  localparam logic [31:0] RESET_WORD  = {RESET_HI, RESET_LO};
  localparam logic [7:0]  SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, PENDING, APPLY} state_t;

  state_t      state, state_d;
  logic [31:0] reg_q;
  logic [31:0] cand, cand_d;
  logic [7:0]  cnt, cnt_d;
  logic        apply;
  logic [31:0] active;

  assign active = {coef_hi, coef_lo};

  // Every decision uses the registered copy reg_q; reg_data is only sampled.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    state_d = state;
    cand_d  = cand;
    cnt_d   = cnt;
    apply   = 1'b0;
    case (state)
      IDLE: begin
        if (reg_q != active) begin
          cand_d  = reg_q;
          cnt_d   = '0;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (reg_q != cand) begin
          cand_d = reg_q;
          cnt_d  = '0;
        end else if (cnt == SETTLE_LAST) begin
          // A word that settled back onto the active pair needs no apply.
          state_d = (cand == active) ? IDLE : PENDING;
        end else begin
          cnt_d = cnt + 8'd1;
        end
      end
      PENDING: begin
        // A change beats a coincident frame_sync; the stale candidate is dropped.
        if (reg_q != cand) begin
          cand_d  = reg_q;
          cnt_d   = '0;
          state_d = SETTLE;
        end else if (frame_sync) begin
          state_d = APPLY;
        end
      end
      APPLY: begin
        apply   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      reg_q          <= RESET_WORD;
      cand           <= RESET_WORD;
      cnt            <= '0;
      state          <= IDLE;
      coef_hi        <= RESET_HI;
      coef_lo        <= RESET_LO;
      coef_valid     <= 1'b0;
      update_pending <= 1'b0;
      update_count   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      reg_q          <= reg_data;
      cand           <= cand_d;
      cnt            <= cnt_d;
      state          <= state_d;
      update_pending <= (state_d == PENDING);
      coef_valid     <= apply;
      if (apply) begin
        coef_hi      <= cand[31:16];
        coef_lo      <= cand[15:0];
        update_count <= update_count + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_fir_coeff_pair_loader.sv
// Randomised and directed bench for fir_coeff_pair_loader against a run-length
// reference model of the qualify/pend/apply behaviour.
module tb_fir_coeff_pair_loader;

  localparam int SETTLE = 4;

  logic        user_clk = 1'b0;
  logic        user_rst_n;
  logic [31:0] reg_data;
  logic        frame_sync;
  logic [15:0] coef_hi, coef_lo;
  logic        coef_valid, update_pending;
  logic [7:0]  update_count;

  fir_coeff_pair_loader #(.SETTLE_CYCLES(SETTLE)) dut (
    .user_clk       (user_clk),
    .user_rst_n     (user_rst_n),
    .reg_data       (reg_data),
    .frame_sync     (frame_sync),
    .coef_hi        (coef_hi),
    .coef_lo        (coef_lo),
    .coef_valid     (coef_valid),
    .update_pending (update_pending),
    .update_count   (update_count)
  );

  always #5 user_clk = ~user_clk;

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  int edge_no = 0;
  int first_valid_edge = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: the input word is tracked as a run of identical samples.
  // A run of SETTLE+1 samples that differs from the active pair becomes pending;
  // pending plus frame_sync applies on the following edge, which ignores input.
  logic [31:0] m_reg_q, m_active, m_run;
  int          m_len;
  bit          m_pend, m_blind, m_valid;
  logic [7:0]  m_count;

  task automatic model_reset();
    m_reg_q  = 32'h0;
    m_active = 32'h0;
    m_run    = 32'h0;
    m_len    = 0;
    m_pend   = 0;
    m_blind  = 0;
    m_valid  = 0;
    m_count  = 8'd0;
  endtask

  task automatic model_step(input logic [31:0] d, input logic fs);
    logic [31:0] s;
    s = m_reg_q;
    m_valid = 0;
    if (m_blind) begin
      m_active = m_run;
      m_count  = m_count + 8'd1;
      m_valid  = 1;
      m_blind  = 0;
      m_len    = 0;
    end else if (m_len == 0) begin
      if (s != m_active) begin
        m_run = s;
        m_len = 1;
      end
    end else if (s != m_run) begin
      m_run  = s;
      m_len  = 1;
      m_pend = 0;
    end else if (m_pend) begin
      if (fs) begin
        m_pend  = 0;
        m_blind = 1;
      end
    end else begin
      m_len++;
      if (m_len == SETTLE + 1) begin
        if (m_run == m_active) m_len = 0;
        else m_pend = 1;
      end
    end
    m_reg_q = d;
  endtask

  task automatic step(input logic [31:0] d, input logic fs);
    reg_data   = d;
    frame_sync = fs;
    @(posedge user_clk);
    model_step(d, fs);
    edge_no++;
    @(negedge user_clk);
    check("coef_hi", 32'(coef_hi), 32'(m_active[31:16]));
    check("coef_lo", 32'(coef_lo), 32'(m_active[15:0]));
    check("coef_valid", 32'(coef_valid), 32'(m_valid));
    check("update_pending", 32'(update_pending), 32'(m_pend));
    check("update_count", 32'(update_count), 32'(m_count));
    if (coef_valid) begin
      pulses++;
      if (first_valid_edge == 0) first_valid_edge = edge_no;
    end
  endtask

  task automatic do_reset();
    user_rst_n = 1'b0;
    reg_data   = 32'h0;
    frame_sync = 1'b0;
    @(negedge user_clk);
    model_reset();
    user_rst_n = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_hi"}, 32'(coef_hi), 32'h0);
    check({tag, "_lo"}, 32'(coef_lo), 32'h0);
    check({tag, "_valid"}, 32'(coef_valid), 32'h0);
    check({tag, "_pending"}, 32'(update_pending), 32'h0);
    check({tag, "_count"}, 32'(update_count), 32'h0);
  endtask

  initial begin
    int p0;
    logic [31:0] pool [4];
    logic [31:0] w;
    int hold;

    user_rst_n = 1'b0;
    reg_data   = 32'h0;
    frame_sync = 1'b0;
    repeat (2) @(negedge user_clk);
    check_reset_outputs("reset");
    model_reset();
    user_rst_n = 1'b1;

    // Idle after release: no pulse in 20 cycles
    repeat (20) step(32'h0, $urandom_range(0, 1) == 1);
    check("idle_pulses", 32'(pulses), 32'd0);

    // Basic update lands at edge SETTLE+4
    edge_no = 0; first_valid_edge = 0; p0 = pulses;
    repeat (12) step(32'h1234_FEDC, 1'b1);
    check("basic_edge", 32'(first_valid_edge), 32'(SETTLE + 4));
    check("basic_word", {coef_hi, coef_lo}, 32'h1234_FEDC);
    check("basic_pulses", 32'(pulses - p0), 32'd1);
    check("basic_count", 32'(update_count), 32'd1);

    // Settle restart: only the second word is applied
    p0 = pulses;
    repeat (2) step(32'h0001_0002, 1'b1);
    repeat (15) step(32'h0003_0004, 1'b1);
    check("restart_word", {coef_hi, coef_lo}, 32'h0003_0004);
    check("restart_pulses", 32'(pulses - p0), 32'd1);

    // Frame gating: pending holds without frame_sync
    p0 = pulses;
    repeat (50) step(32'hAAAA_5555, 1'b0);
    check("gate_pending", 32'(update_pending), 32'd1);
    check("gate_word", {coef_hi, coef_lo}, 32'h0003_0004);
    // Collision: the registered change meets the frame_sync pulse
    step(32'hBBBB_6666, 1'b0);
    step(32'hBBBB_6666, 1'b1);
    repeat (3) step(32'hBBBB_6666, 1'b0);
    check("collide_pulses", 32'(pulses - p0), 32'd0);
    check("collide_word", {coef_hi, coef_lo}, 32'h0003_0004);
    repeat (5) step(32'hBBBB_6666, 1'b0);
    step(32'hBBBB_6666, 1'b1);
    repeat (3) step(32'hBBBB_6666, 1'b0);
    check("collide_apply", {coef_hi, coef_lo}, 32'hBBBB_6666);
    check("collide_pulses2", 32'(pulses - p0), 32'd1);

    // Revert before settle completes: no apply
    p0 = pulses;
    repeat (2) step(32'h0000_0010, 1'b1);
    repeat (20) step(32'hBBBB_6666, 1'b1);
    check("revert_pulses", 32'(pulses - p0), 32'd0);
    check("revert_count", 32'(update_count), 32'd3);

    // Randomised traffic against the model
    pool[0] = 32'h0; pool[1] = 32'h1111_2222; pool[2] = 32'hDEAD_BEEF; pool[3] = 32'h8000_7FFF;
    for (int i = 0; i < 250; i++) begin
      w = ($urandom_range(0, 4) == 4) ? $urandom : pool[$urandom_range(0, 3)];
      hold = $urandom_range(1, 9);
      for (int j = 0; j < hold; j++) step(w, $urandom_range(0, 3) == 0);
    end

    // 256 distinct updates wrap the counter
    do_reset();
    p0 = pulses;
    for (int i = 1; i <= 256; i++) begin
      w = {16'(i), 16'(i) ^ 16'h5A5A};
      repeat (9) step(w, 1'b1);
    end
    check("wrap_pulses", 32'(pulses - p0), 32'd256);
    check("wrap_count", 32'(update_count), 32'd0);

    // Reset while pending is asynchronous; the word is re-qualified afterwards
    repeat (10) step(32'h7777_8888, 1'b0);
    check("mid_pending", 32'(update_pending), 32'd1);
    user_rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    @(negedge user_clk);
    model_reset();
    user_rst_n = 1'b1;
    edge_no = 0; first_valid_edge = 0;
    repeat (10) step(32'h7777_8888, 1'b1);
    check("requal_edge", 32'(first_valid_edge), 32'(SETTLE + 4));
    check("requal_word", {coef_hi, coef_lo}, 32'h7777_8888);
    check("requal_count", 32'(update_count), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
